// File: rtl/spfp_lsq_port_pkg.sv
// Shared definitions for the single-precision FP load/store port.
// Contents:
//   lsq_state_e  - port FSM states
//   CAUSE_*      - exception cause codes returned with a response
//   SPFP_LS_RSP  - control/index/cause fields of one response
//   mis_cause / fault_cause - pick the cause code from the op direction
package spfp_lsq_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } lsq_state_e;

    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    // Load data is kept outside the struct so its width can follow FLEN.
    typedef struct packed {
        logic       valid;
        logic       fd_wr;
        logic       exc;
        logic [3:0] cause;
        logic [4:0] idx;
    } SPFP_LS_RSP;

    function automatic logic [3:0] mis_cause(input logic is_st);
        return is_st ? CAUSE_ST_MIS : CAUSE_LD_MIS;
    endfunction

    function automatic logic [3:0] fault_cause(input logic is_st);
        return is_st ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    endfunction

endpackage

// File: rtl/spfp_lsq_port_tmo_counter.sv
// Watchdog for the memory request.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clr       - restart the count at zero (start of a new request)
//   en        - count this cycle (request outstanding)
//   expired   - high in the TMO_CYC-th enabled cycle since clr
module tmo_counter #(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds the number of enabled cycles already elapsed, so the
    // current enabled cycle is the last one when r_cnt == TMO_CYC-1.
    assign expired = en && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spfp_lsq_port.sv
// Single-entry FLW/FSW memory port behind the SPFP functional unit.
// Captures one op, runs the req/ack handshake with the data-memory arbiter
// and returns one registered response (load data or exception).
// Ports:
//   clk_in, reset_in          - clock, asynchronous active-high reset
//   start_in/is_st_in/...     - op from the SPFP unit (taken when !busy_out)
//   flush_in                  - kill the pending response
//   mem_*                     - memory arbiter handshake
//   busy_out                  - entry occupied
//   rsp_*                     - one-cycle response to FP writeback
module spfp_lsq_port
    import spfp_lsq_port_pkg::*;
#(
    parameter int FLEN    = 32,
    parameter int PC_SZ   = 32,
    parameter int TMO_CYC = 64
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             is_st_in,
    input  logic [PC_SZ-1:0] ls_addr_in,
    input  logic [FLEN-1:0]  st_data_in,
    input  logic             mis_in,
    input  logic [4:0]       Fd_idx_in,
    input  logic             flush_in,
    output logic             mem_req_out,
    output logic             mem_rw_out,
    output logic [PC_SZ-1:0] mem_addr_out,
    output logic [FLEN-1:0]  mem_wdata_out,
    input  logic             mem_ack_in,
    input  logic [FLEN-1:0]  mem_rdata_in,
    input  logic             mem_fault_in,
    output logic             busy_out,
    output logic             rsp_valid_out,
    output logic             rsp_Fd_wr_out,
    output logic [4:0]       rsp_Fd_idx_out,
    output logic [FLEN-1:0]  rsp_Fd_data_out,
    output logic             rsp_exc_out,
    output logic [3:0]       rsp_cause_out
);
    localparam logic [PC_SZ-1:0] ADDR_MASK = {{(PC_SZ-2){1'b1}}, 2'b00};

    lsq_state_e       r_state;
    SPFP_LS_RSP       r_rsp;
    logic [FLEN-1:0]  r_rsp_data;
    logic             r_is_st;
    logic             r_mem_req;
    logic             r_mem_rw;
    logic [PC_SZ-1:0] r_mem_addr;
    logic [FLEN-1:0]  r_mem_wdata;
    logic             r_busy;

    logic w_accept;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_expired;

    // A start coinciding with a flush is dropped.
    assign w_accept  = (r_state == ST_IDLE) && start_in && !flush_in;
    assign w_tmo_clr = w_accept && !mis_in;
    // DRAIN keeps counting so a dead memory cannot hold the port forever.
    assign w_tmo_en  = (r_state == ST_REQ) || (r_state == ST_DRAIN);

    tmo_counter #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk     (clk_in),
        .rst     (reset_in),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= ST_IDLE;
            r_rsp       <= '0;
            r_rsp_data  <= '0;
            r_is_st     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            // valid/fd_wr/exc are pulses qualified by the RESP cycle only
            r_rsp.valid <= 1'b0;
            r_rsp.fd_wr <= 1'b0;
            r_rsp.exc   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_st     <= is_st_in;
                        r_rsp.idx   <= Fd_idx_in;
                        r_mem_rw    <= is_st_in;
                        r_mem_addr  <= ls_addr_in & ADDR_MASK;
                        r_mem_wdata <= st_data_in;
                        r_busy      <= 1'b1;
                        if (mis_in) begin
                            r_state     <= ST_RESP;
                            r_rsp.valid <= 1'b1;
                            r_rsp.exc   <= 1'b1;
                            r_rsp.cause <= mis_cause(is_st_in);
                            r_rsp_data  <= '0;
                        end else begin
                            r_state   <= ST_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    if (mem_ack_in) begin
                        r_mem_req <= 1'b0;
                        if (flush_in) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp.valid <= 1'b1;
                            r_rsp.exc   <= mem_fault_in;
                            r_rsp.fd_wr <= !r_is_st && !mem_fault_in;
                            if (mem_fault_in) begin
                                r_rsp.cause <= fault_cause(r_is_st);
                            end
                            r_rsp_data  <= (!r_is_st && !mem_fault_in) ? mem_rdata_in : '0;
                        end
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        if (flush_in) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp.valid <= 1'b1;
                            r_rsp.exc   <= 1'b1;
                            r_rsp.cause <= fault_cause(r_is_st);
                            r_rsp_data  <= '0;
                        end
                    end else if (flush_in) begin
                        // request stays up until the memory finishes it
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (mem_ack_in || w_expired) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_out     = r_mem_req;
    assign mem_rw_out      = r_mem_rw;
    assign mem_addr_out    = r_mem_addr;
    assign mem_wdata_out   = r_mem_wdata;
    assign busy_out        = r_busy;
    // Only output with a combinational path: a flush in RESP kills the pulse.
    assign rsp_valid_out   = r_rsp.valid && !flush_in;
    assign rsp_Fd_wr_out   = r_rsp.fd_wr;
    assign rsp_Fd_idx_out  = r_rsp.idx;
    assign rsp_Fd_data_out = r_rsp_data;
    assign rsp_exc_out     = r_rsp.exc;
    assign rsp_cause_out   = r_rsp.cause;

endmodule

// File: tb/tb_spfp_lsq_port.sv
module tb_spfp_lsq_port;

    localparam int FLEN    = 32;
    localparam int PC_SZ   = 32;
    localparam int TMO_CYC = 6;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic             start_in;
    logic             is_st_in;
    logic [PC_SZ-1:0] ls_addr_in;
    logic [FLEN-1:0]  st_data_in;
    logic             mis_in;
    logic [4:0]       Fd_idx_in;
    logic             flush_in;
    logic             mem_req_out;
    logic             mem_rw_out;
    logic [PC_SZ-1:0] mem_addr_out;
    logic [FLEN-1:0]  mem_wdata_out;
    logic             mem_ack_in;
    logic [FLEN-1:0]  mem_rdata_in;
    logic             mem_fault_in;
    logic             busy_out;
    logic             rsp_valid_out;
    logic             rsp_Fd_wr_out;
    logic [4:0]       rsp_Fd_idx_out;
    logic [FLEN-1:0]  rsp_Fd_data_out;
    logic             rsp_exc_out;
    logic [3:0]       rsp_cause_out;

    int n_tests = 0;
    int n_fail  = 0;

    spfp_lsq_port #(
        .FLEN    (FLEN),
        .PC_SZ   (PC_SZ),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .is_st_in        (is_st_in),
        .ls_addr_in      (ls_addr_in),
        .st_data_in      (st_data_in),
        .mis_in          (mis_in),
        .Fd_idx_in       (Fd_idx_in),
        .flush_in        (flush_in),
        .mem_req_out     (mem_req_out),
        .mem_rw_out      (mem_rw_out),
        .mem_addr_out    (mem_addr_out),
        .mem_wdata_out   (mem_wdata_out),
        .mem_ack_in      (mem_ack_in),
        .mem_rdata_in    (mem_rdata_in),
        .mem_fault_in    (mem_fault_in),
        .busy_out        (busy_out),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_Fd_wr_out   (rsp_Fd_wr_out),
        .rsp_Fd_idx_out  (rsp_Fd_idx_out),
        .rsp_Fd_data_out (rsp_Fd_data_out),
        .rsp_exc_out     (rsp_exc_out),
        .rsp_cause_out   (rsp_cause_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic nxt();
        @(negedge clk_in);
    endtask

    task automatic idle_inputs();
        start_in     = 1'b0;
        is_st_in     = 1'b0;
        ls_addr_in   = '0;
        st_data_in   = '0;
        mis_in       = 1'b0;
        Fd_idx_in    = '0;
        flush_in     = 1'b0;
        mem_ack_in   = 1'b0;
        mem_rdata_in = '0;
        mem_fault_in = 1'b0;
    endtask

    task automatic op(input logic st, input logic [31:0] addr, input logic [31:0] data,
                      input logic [4:0] idx);
        start_in   = 1'b1;
        is_st_in   = st;
        ls_addr_in = addr;
        st_data_in = data;
        mis_in     = (addr[1:0] != 2'b00);
        Fd_idx_in  = idx;
    endtask

    initial begin
        idle_inputs();
        reset_in = 1'b1;
        repeat (2) nxt();
        #1;
        // ---- reset state
        chk("rst_req",   64'(mem_req_out), 64'h0);
        chk("rst_busy",  64'(busy_out), 64'h0);
        chk("rst_valid", 64'(rsp_valid_out), 64'h0);
        chk("rst_fdwr",  64'(rsp_Fd_wr_out), 64'h0);
        chk("rst_exc",   64'(rsp_exc_out), 64'h0);
        chk("rst_data",  64'(rsp_Fd_data_out), 64'h0);
        chk("rst_cause", 64'(rsp_cause_out), 64'h0);
        chk("rst_addr",  64'(mem_addr_out), 64'h0);
        nxt(); reset_in = 1'b0;
        nxt();

        // ---- aligned FLW, ack at cycle 3
        op(1'b0, 32'h1000, 32'h0, 5'd3);                         // cycle 0
        nxt(); idle_inputs(); #1;                                // cycle 1
        chk("flw_req1", 64'(mem_req_out), 64'h1);
        chk("flw_rw",   64'(mem_rw_out), 64'h0);
        chk("flw_addr", 64'(mem_addr_out), 64'h1000);
        chk("flw_busy", 64'(busy_out), 64'h1);
        nxt(); #1;                                               // cycle 2
        chk("flw_req2", 64'(mem_req_out), 64'h1);
        nxt(); mem_ack_in = 1'b1; mem_rdata_in = 32'h3F800000; #1; // cycle 3
        chk("flw_req3", 64'(mem_req_out), 64'h1);
        chk("flw_nov3", 64'(rsp_valid_out), 64'h0);
        nxt(); idle_inputs(); #1;                                // cycle 4
        chk("flw_valid", 64'(rsp_valid_out), 64'h1);
        chk("flw_fdwr",  64'(rsp_Fd_wr_out), 64'h1);
        chk("flw_idx",   64'(rsp_Fd_idx_out), 64'h3);
        chk("flw_data",  64'(rsp_Fd_data_out), 64'h3F800000);
        chk("flw_exc",   64'(rsp_exc_out), 64'h0);
        chk("flw_req4",  64'(mem_req_out), 64'h0);
        nxt(); #1;                                               // cycle 5
        chk("flw_pulse", 64'(rsp_valid_out), 64'h0);
        chk("flw_idle",  64'(busy_out), 64'h0);

        // ---- aligned FSW, ack at cycle 1
        op(1'b1, 32'h2004, 32'h40490FDB, 5'd0);
        nxt(); idle_inputs(); mem_ack_in = 1'b1; #1;             // cycle 1
        chk("fsw_req",   64'(mem_req_out), 64'h1);
        chk("fsw_rw",    64'(mem_rw_out), 64'h1);
        chk("fsw_addr",  64'(mem_addr_out), 64'h2004);
        chk("fsw_wdata", 64'(mem_wdata_out), 64'h40490FDB);
        nxt(); idle_inputs(); #1;                                // cycle 2
        chk("fsw_valid", 64'(rsp_valid_out), 64'h1);
        chk("fsw_fdwr",  64'(rsp_Fd_wr_out), 64'h0);
        chk("fsw_exc",   64'(rsp_exc_out), 64'h0);
        nxt();

        // ---- misaligned FLW
        op(1'b0, 32'h1002, 32'h0, 5'd7);
        nxt(); idle_inputs(); #1;                                // cycle 1
        chk("mis_req",   64'(mem_req_out), 64'h0);
        chk("mis_valid", 64'(rsp_valid_out), 64'h1);
        chk("mis_exc",   64'(rsp_exc_out), 64'h1);
        chk("mis_cause", 64'(rsp_cause_out), 64'h4);
        chk("mis_fdwr",  64'(rsp_Fd_wr_out), 64'h0);
        chk("mis_idx",   64'(rsp_Fd_idx_out), 64'h7);
        nxt(); #1;
        chk("mis_pulse", 64'(rsp_valid_out), 64'h0);

        // ---- FSW with memory fault
        op(1'b1, 32'h3000, 32'hDEADBEEF, 5'd0);
        nxt(); idle_inputs(); mem_ack_in = 1'b1; mem_fault_in = 1'b1; #1;
        chk("sft_req",   64'(mem_req_out), 64'h1);
        nxt(); idle_inputs(); #1;
        chk("sft_valid", 64'(rsp_valid_out), 64'h1);
        chk("sft_exc",   64'(rsp_exc_out), 64'h1);
        chk("sft_cause", 64'(rsp_cause_out), 64'h7);
        chk("sft_fdwr",  64'(rsp_Fd_wr_out), 64'h0);
        nxt();

        // ---- FLW with memory fault
        op(1'b0, 32'h3100, 32'h0, 5'd2);
        nxt(); idle_inputs(); mem_ack_in = 1'b1; mem_fault_in = 1'b1;
        mem_rdata_in = 32'h12345678;
        nxt(); idle_inputs(); #1;
        chk("lft_cause", 64'(rsp_cause_out), 64'h5);
        chk("lft_fdwr",  64'(rsp_Fd_wr_out), 64'h0);
        nxt();

        // ---- timeout (TMO_CYC = 6): request cycles 1..6, fault at cycle 7
        op(1'b0, 32'h4000, 32'h0, 5'd9);
        nxt(); idle_inputs();                                    // cycle 1
        repeat (5) nxt();                                        // cycle 6
        #1;
        chk("tmo_req6",  64'(mem_req_out), 64'h1);
        chk("tmo_nov6",  64'(rsp_valid_out), 64'h0);
        nxt(); #1;                                               // cycle 7
        chk("tmo_req7",  64'(mem_req_out), 64'h0);
        chk("tmo_valid", 64'(rsp_valid_out), 64'h1);
        chk("tmo_exc",   64'(rsp_exc_out), 64'h1);
        chk("tmo_cause", 64'(rsp_cause_out), 64'h5);
        nxt(); nxt(); nxt(); mem_ack_in = 1'b1;                  // cycle 10 late ack
        nxt(); idle_inputs(); #1;                                // cycle 11
        chk("late_valid", 64'(rsp_valid_out), 64'h0);
        chk("late_busy",  64'(busy_out), 64'h0);
        chk("late_req",   64'(mem_req_out), 64'h0);

        // ---- flush in REQ at cycle 2, ack at cycle 5
        op(1'b0, 32'h5000, 32'h0, 5'd4);
        nxt(); idle_inputs();                                    // cycle 1
        nxt(); flush_in = 1'b1;                                  // cycle 2
        nxt(); idle_inputs(); op(1'b1, 32'h6000, 32'hAAAA5555, 5'd1); #1; // cycle 3
        chk("fl_busy3", 64'(busy_out), 64'h1);
        chk("fl_req3",  64'(mem_req_out), 64'h1);
        nxt(); idle_inputs(); #1;                                // cycle 4
        chk("fl_addr",  64'(mem_addr_out), 64'h5000);
        chk("fl_rw",    64'(mem_rw_out), 64'h0);
        nxt(); mem_ack_in = 1'b1; #1;                            // cycle 5
        chk("fl_req5",  64'(mem_req_out), 64'h1);
        nxt(); idle_inputs(); #1;                                // cycle 6
        chk("fl_busy6", 64'(busy_out), 64'h0);
        chk("fl_req6",  64'(mem_req_out), 64'h0);
        chk("fl_valid", 64'(rsp_valid_out), 64'h0);
        nxt(); #1;
        chk("fl_nov7",  64'(rsp_valid_out), 64'h0);
        chk("fl_busy7", 64'(busy_out), 64'h0);

        // ---- flush in RESP gates the pulse
        op(1'b1, 32'h7001, 32'h0, 5'd0);
        nxt(); idle_inputs(); flush_in = 1'b1; #1;
        chk("flr_valid", 64'(rsp_valid_out), 64'h0);
        chk("flr_cause", 64'(rsp_cause_out), 64'h6);
        nxt(); idle_inputs(); #1;
        chk("flr_busy",  64'(busy_out), 64'h0);

        // ---- start together with flush in IDLE is ignored
        op(1'b0, 32'h8000, 32'h0, 5'd5); flush_in = 1'b1;
        nxt(); idle_inputs(); #1;
        chk("fls_busy", 64'(busy_out), 64'h0);
        chk("fls_req",  64'(mem_req_out), 64'h0);

        // ---- asynchronous reset mid-request
        op(1'b0, 32'h9000, 32'h0, 5'd6);
        nxt(); idle_inputs(); #1;
        chk("ar_req1", 64'(mem_req_out), 64'h1);
        #2 reset_in = 1'b1; #1;
        chk("ar_req0",  64'(mem_req_out), 64'h0);
        chk("ar_busy0", 64'(busy_out), 64'h0);
        nxt(); reset_in = 1'b0;
        nxt(); #1;
        chk("ar_idle", 64'(busy_out), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
